i2c_addr_decoder: RTL and testbench
===================================

// Module: i2c_addr_decoder
// PURPOSE
// - Parametrised successor to the single-byte device-ID latch. Sits between the
//   I2C slave shift register and the flash command controller.
// - Decodes the address phase after each START: 7-bit, optional 10-bit, and optional general call.
// - Hardware strap pins override the low address bits, so several flash devices can share one bus.
// - Publishes R/W (WR), match status and a one-cycle ACK request to the controller.
// PARAMETERS
// DEV_ADDR      7'h50     base 7-bit slave address
// ADDR_PIN_W    3         number of low address bits taken from AddrPins (0..7)
// TEN_BIT_EN    0         1 = also respond to TEN_BIT_ADDR in 10-bit mode
// TEN_BIT_ADDR  10'h250   10-bit slave address
// GCALL_EN      0         1 = respond to general call 8'h00
// PORTS
// SCL           in   1           bus clock; all state updates on negedge SCL
// Reset_n       in   1           asynchronous, active-low reset
// ShiftRegOut   in   8           received byte, MSB first on the wire; [0] = R/W in byte 1
// LoadDeviceId  in   1           byte-complete strobe; sampled at negedge SCL
// StartDet      in   1           START or repeated START seen; held until the next negedge
// StopDet       in   1           STOP seen; held until the next negedge
// AddrPins      in   ADDR_PIN_W  strap pins
// WR            out  1           latched R/W bit: 1 = read (master reads from flash)
// AddrMatch     out  1           this device is addressed for the current transfer
// AckReq        out  1           one-SCL-cycle pulse: drive ACK on the next bit
// GeneralCall   out  1           current transfer is a general call
// TenBitActive  out  1           current match was made in 10-bit mode
// DevId         out  8           last address byte received (byte 1)
// BEHAVIOUR
// - Reset (async): state=IDLE; all outputs 0; internal tenbit_hist=0.
// - Effective 7-bit address: eff = {DEV_ADDR[6:ADDR_PIN_W], AddrPins}.
//   When ADDR_PIN_W=0, eff = DEV_ADDR.
// - FSM states: IDLE, ADDR1, ADDR2, ACTIVE, IGNORE.
// - StartDet=1 in any state -> ADDR1.
//   - Clears AddrMatch, GeneralCall, TenBitActive.
//   - Keeps WR and tenbit_hist.
//   - Priority: StartDet > StopDet > LoadDeviceId.
// - StopDet=1 -> IDLE. Clears AddrMatch, GeneralCall, TenBitActive and tenbit_hist.
// - ADDR1 + LoadDeviceId: DevId<=ShiftRegOut and WR<=ShiftRegOut[0], then decode in order:
//   1. ShiftRegOut[7:1]==eff -> ACTIVE, AddrMatch=1, AckReq pulse.
//   2. GCALL_EN and ShiftRegOut==8'h00 -> ACTIVE, AddrMatch=1, GeneralCall=1, AckReq.
//   3. TEN_BIT_EN and ShiftRegOut[7:3]==5'b11110 and [2:1]==TEN_BIT_ADDR[9:8]:
//      - [0]=0 -> ADDR2 with AckReq (tentative ACK of the upper address bits).
//      - [0]=1 and tenbit_hist=1 (repeated-START read) -> ACTIVE, AddrMatch=1,
//        TenBitActive=1, AckReq.
//      - [0]=1 and tenbit_hist=0 -> IGNORE, no AckReq.
//   4. Otherwise -> IGNORE, no AckReq; tenbit_hist<=0.
// - ADDR2 + LoadDeviceId:
//   - ShiftRegOut==TEN_BIT_ADDR[7:0] -> ACTIVE, AddrMatch=1, TenBitActive=1,
//     tenbit_hist=1, AckReq.
//   - Otherwise -> IGNORE, tenbit_hist=0.
// - ACTIVE / IGNORE: LoadDeviceId is ignored; outputs hold until START, STOP or reset.
// - AckReq: exactly one negedge cycle wide, asserted in the same cycle as the decision.
//   Never asserted in IDLE or IGNORE.
// - LoadDeviceId in IDLE is ignored (no START yet).
// - Reset mid-byte: immediate return to IDLE; a partial byte is never decoded.
// - Latency: decision visible on outputs 1 negedge after the LoadDeviceId sample.
// STRUCTURE
// - Shared package i2c_pkg: FSM state encoding, 5'b11110 10-bit prefix, 8'h00 general-call code.
// - One sub-module, i2c_addr_cmp: combinational compare of byte vs eff/TEN_BIT_ADDR.
//   Outputs hit7, hitGc, hit10hi, hit10lo.
// - Everything else stays in one always block plus the FSM.
// TESTING
// 1. DEV_ADDR=7'h50, ADDR_PIN_W=3, AddrPins=3'b011; START, byte 8'hA7 ->
//    AddrMatch=1, WR=1, AckReq one cycle, DevId=8'hA7.
// 2. Same config, byte 8'hA1 (pins mismatch) -> IGNORE, AckReq=0, AddrMatch=0.
//    A later 8'hA6 without START -> still no match.
// 3. TEN_BIT_EN=1, TEN_BIT_ADDR=10'h250; START, 8'hF4, 8'h50 -> AckReq twice, TenBitActive=1, WR=0.
//    Then repeated START, 8'hF5 -> AddrMatch=1, WR=1.
// 4. 10-bit: STOP, START, 8'hF5 -> IGNORE (tenbit_hist cleared), AckReq=0.
// 5. GCALL_EN=1: START, 8'h00 -> GeneralCall=1, AckReq.
//    GCALL_EN=0 with the same sequence -> IGNORE.
// 6. Reset_n low during ADDR2 -> all outputs 0 immediately, state IDLE.
//    StartDet and LoadDeviceId in the same cycle -> START wins, byte not decoded.

Source files
------------

// File: rtl/i2c_pkg.sv
// Purpose : shared types and constants for the I2C slave address decoder.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   state_t         address-phase FSM state encoding
//   TEN_BIT_PREFIX  upper five bits of a 10-bit address first byte (11110)
//   GCALL_CODE      general-call address byte
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ADDR1  = 3'd1,
      ST_ADDR2  = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_IGNORE = 3'd4
   } state_t;

   localparam logic [4:0] TEN_BIT_PREFIX = 5'b11110;
   localparam logic [7:0] GCALL_CODE     = 8'h00;

endpackage

// File: rtl/i2c_addr_cmp.sv
// Purpose : combinational compare of a received address byte against this device's addresses.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
//
// Ports:
//   Byte     in  8  received byte (bit 0 is R/W in the first address byte)
//   Eff      in  7  effective 7-bit address (base address with strap bits applied)
//   hit7     out 1  byte[7:1] equals the effective 7-bit address
//   hitGc    out 1  general call byte seen and general call is enabled
//   hit10hi  out 1  10-bit first byte whose address bits match TEN_BIT_ADDR[9:8] (enabled only)
//   hit10lo  out 1  byte equals TEN_BIT_ADDR[7:0] (second byte of a 10-bit address)
module i2c_addr_cmp
   import i2c_pkg::*;
#(
   parameter bit         TEN_BIT_EN   = 1'b0,
   parameter logic [9:0] TEN_BIT_ADDR = 10'h250,
   parameter bit         GCALL_EN     = 1'b0
) (
   input  logic [7:0] Byte,
   input  logic [6:0] Eff,
   output logic       hit7,
   output logic       hitGc,
   output logic       hit10hi,
   output logic       hit10lo
);

   assign hit7    = (Byte[7:1] == Eff);
   assign hitGc   = GCALL_EN && (Byte == GCALL_CODE);
   assign hit10hi = TEN_BIT_EN && (Byte[7:3] == TEN_BIT_PREFIX)
                    && (Byte[2:1] == TEN_BIT_ADDR[9:8]);
   assign hit10lo = (Byte == TEN_BIT_ADDR[7:0]);

endmodule

// File: rtl/i2c_addr_decoder.sv
// Purpose : decodes the I2C address phase (7-bit, optional 10-bit, optional general call) after each START.
// Latency : decision visible one SCL negedge after the LoadDeviceId sample.
// Backpressure: none; every byte strobe is consumed in the cycle it is sampled.
//
// Ports:
//   SCL          in   1   bus clock, all state updates on its falling edge
//   Reset_n      in   1   asynchronous active-low reset
//   ShiftRegOut  in   8   received byte from the slave shift register
//   LoadDeviceId in   1   byte-complete strobe
//   StartDet     in   1   START / repeated START seen
//   StopDet      in   1   STOP seen
//   AddrPins     in   W   strap pins replacing the low address bits
//   WR           out  1   latched R/W bit (1 = master reads)
//   AddrMatch    out  1   this device is addressed
//   AckReq       out  1   one-cycle request to drive ACK on the next bit
//   GeneralCall  out  1   current transfer is a general call
//   TenBitActive out  1   match was made in 10-bit mode
//   DevId        out  8   first address byte of the current transfer
module i2c_addr_decoder
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR     = 7'h50,
   parameter int         ADDR_PIN_W   = 3,
   parameter bit         TEN_BIT_EN   = 1'b0,
   parameter logic [9:0] TEN_BIT_ADDR = 10'h250,
   parameter bit         GCALL_EN     = 1'b0
) (
   input  logic                                        SCL,
   input  logic                                        Reset_n,
   input  logic [7:0]                                  ShiftRegOut,
   input  logic                                        LoadDeviceId,
   input  logic                                        StartDet,
   input  logic                                        StopDet,
   input  logic [(ADDR_PIN_W > 0 ? ADDR_PIN_W : 1)-1:0] AddrPins,
   output logic                                        WR,
   output logic                                        AddrMatch,
   output logic                                        AckReq,
   output logic                                        GeneralCall,
   output logic                                        TenBitActive,
   output logic [7:0]                                  DevId
);

   logic [6:0] w_eff;
   logic       w_hit7;
   logic       w_hit_gc;
   logic       w_hit10hi;
   logic       w_hit10lo;

   state_t     r_state;
   // Set once a full 10-bit write address has matched; lets a repeated-START
   // read with only the 11110xx1 byte re-address this device.
   logic       r_tenbit_hist;

   // Strap pins replace the low address bits so several devices can share a bus.
   generate
      if (ADDR_PIN_W == 0) begin : g_no_pins
         logic w_unused_pins;
         assign w_unused_pins = ^AddrPins;
         assign w_eff         = DEV_ADDR;
      end else if (ADDR_PIN_W >= 7) begin : g_all_pins
         assign w_eff = AddrPins[6:0];
      end else begin : g_some_pins
         assign w_eff = {DEV_ADDR[6:ADDR_PIN_W], AddrPins};
      end
   endgenerate

   i2c_addr_cmp #(
      .TEN_BIT_EN   (TEN_BIT_EN),
      .TEN_BIT_ADDR (TEN_BIT_ADDR),
      .GCALL_EN     (GCALL_EN)
   ) u_cmp (
      .Byte    (ShiftRegOut),
      .Eff     (w_eff),
      .hit7    (w_hit7),
      .hitGc   (w_hit_gc),
      .hit10hi (w_hit10hi),
      .hit10lo (w_hit10lo)
   );

   always_ff @(negedge SCL or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state       <= ST_IDLE;
         r_tenbit_hist <= 1'b0;
         WR            <= 1'b0;
         AddrMatch     <= 1'b0;
         AckReq        <= 1'b0;
         GeneralCall   <= 1'b0;
         TenBitActive  <= 1'b0;
         DevId         <= 8'h00;
      end else begin
         // AckReq is a single-cycle pulse; only a decision below re-asserts it.
         AckReq <= 1'b0;

         if (StartDet) begin
            // WR and the 10-bit history survive a repeated START.
            r_state      <= ST_ADDR1;
            AddrMatch    <= 1'b0;
            GeneralCall  <= 1'b0;
            TenBitActive <= 1'b0;
         end else if (StopDet) begin
            r_state       <= ST_IDLE;
            AddrMatch     <= 1'b0;
            GeneralCall   <= 1'b0;
            TenBitActive  <= 1'b0;
            r_tenbit_hist <= 1'b0;
         end else if (LoadDeviceId) begin
            case (r_state)
               ST_ADDR1: begin
                  DevId <= ShiftRegOut;
                  WR    <= ShiftRegOut[0];
                  if (w_hit7) begin
                     r_state   <= ST_ACTIVE;
                     AddrMatch <= 1'b1;
                     AckReq    <= 1'b1;
                  end else if (w_hit_gc) begin
                     r_state     <= ST_ACTIVE;
                     AddrMatch   <= 1'b1;
                     GeneralCall <= 1'b1;
                     AckReq      <= 1'b1;
                  end else if (w_hit10hi) begin
                     if (!ShiftRegOut[0]) begin
                        // Tentative ACK; the match is only confirmed by the second byte.
                        r_state <= ST_ADDR2;
                        AckReq  <= 1'b1;
                     end else if (r_tenbit_hist) begin
                        r_state      <= ST_ACTIVE;
                        AddrMatch    <= 1'b1;
                        TenBitActive <= 1'b1;
                        AckReq       <= 1'b1;
                     end else begin
                        r_state <= ST_IGNORE;
                     end
                  end else begin
                     r_state       <= ST_IGNORE;
                     r_tenbit_hist <= 1'b0;
                  end
               end
               ST_ADDR2: begin
                  if (w_hit10lo) begin
                     r_state       <= ST_ACTIVE;
                     AddrMatch     <= 1'b1;
                     TenBitActive  <= 1'b1;
                     r_tenbit_hist <= 1'b1;
                     AckReq        <= 1'b1;
                  end else begin
                     r_state       <= ST_IGNORE;
                     r_tenbit_hist <= 1'b0;
                  end
               end
               default: begin
                  // IDLE, ACTIVE and IGNORE do not decode bytes.
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_addr_decoder.sv
// Purpose : directed self-checking bench for i2c_addr_decoder.
// Latency : outputs sampled 1 time unit after each SCL falling edge.
// Backpressure: n/a.
//
// u_a : 10-bit and general call enabled.  u_b : defaults (7-bit only).
// Both use DEV_ADDR 7'h50 with three strap pins tied to 3'b011 -> eff 7'h53.
module tb_i2c_addr_decoder;

   logic       SCL;
   logic       Reset_n;
   logic [7:0] ShiftRegOut;
   logic       LoadDeviceId;
   logic       StartDet;
   logic       StopDet;
   logic [2:0] AddrPins;

   logic       a_wr, a_match, a_ack, a_gc, a_ten;
   logic [7:0] a_devid;
   logic       b_wr, b_match, b_ack, b_gc, b_ten;
   logic [7:0] b_devid;

   int total = 0;
   int bad   = 0;

   i2c_addr_decoder #(
      .DEV_ADDR     (7'h50),
      .ADDR_PIN_W   (3),
      .TEN_BIT_EN   (1'b1),
      .TEN_BIT_ADDR (10'h250),
      .GCALL_EN     (1'b1)
   ) u_a (
      .SCL          (SCL),
      .Reset_n      (Reset_n),
      .ShiftRegOut  (ShiftRegOut),
      .LoadDeviceId (LoadDeviceId),
      .StartDet     (StartDet),
      .StopDet      (StopDet),
      .AddrPins     (AddrPins),
      .WR           (a_wr),
      .AddrMatch    (a_match),
      .AckReq       (a_ack),
      .GeneralCall  (a_gc),
      .TenBitActive (a_ten),
      .DevId        (a_devid)
   );

   i2c_addr_decoder #(
      .DEV_ADDR     (7'h50),
      .ADDR_PIN_W   (3),
      .TEN_BIT_EN   (1'b0),
      .TEN_BIT_ADDR (10'h250),
      .GCALL_EN     (1'b0)
   ) u_b (
      .SCL          (SCL),
      .Reset_n      (Reset_n),
      .ShiftRegOut  (ShiftRegOut),
      .LoadDeviceId (LoadDeviceId),
      .StartDet     (StartDet),
      .StopDet      (StopDet),
      .AddrPins     (AddrPins),
      .WR           (b_wr),
      .AddrMatch    (b_match),
      .AckReq       (b_ack),
      .GeneralCall  (b_gc),
      .TenBitActive (b_ten),
      .DevId        (b_devid)
   );

   initial begin
      SCL = 1'b1;
      forever #5 SCL = ~SCL;
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one bus cycle: inputs change on the rising edge, the DUT samples on
   // the falling edge, outputs are observed 1 unit later.
   task automatic cyc(input logic st, input logic sp, input logic ld, input logic [7:0] b);
      @(posedge SCL);
      StartDet     = st;
      StopDet      = sp;
      LoadDeviceId = ld;
      ShiftRegOut  = b;
      @(negedge SCL);
      #1;
      StartDet     = 1'b0;
      StopDet      = 1'b0;
      LoadDeviceId = 1'b0;
   endtask

   initial begin
      Reset_n      = 1'b0;
      ShiftRegOut  = 8'h00;
      LoadDeviceId = 1'b0;
      StartDet     = 1'b0;
      StopDet      = 1'b0;
      AddrPins     = 3'b011;

      // Reset state
      repeat (2) @(negedge SCL);
      #1;
      chk("rst_match", {7'd0, a_match}, 8'h00);
      chk("rst_wr",    {7'd0, a_wr},    8'h00);
      chk("rst_ack",   {7'd0, a_ack},   8'h00);
      chk("rst_gc",    {7'd0, a_gc},    8'h00);
      chk("rst_ten",   {7'd0, a_ten},   8'h00);
      chk("rst_devid", a_devid,         8'h00);
      @(posedge SCL);
      Reset_n = 1'b1;

      // 1: 7-bit read match with strap pins, byte A7 -> [7:1]=7'h53
      cyc(1, 0, 0, 8'h00);
      cyc(0, 0, 1, 8'hA7);
      chk("t1_match", {7'd0, b_match}, 8'h01);
      chk("t1_wr",    {7'd0, b_wr},    8'h01);
      chk("t1_ack",   {7'd0, b_ack},   8'h01);
      chk("t1_devid", b_devid,         8'hA7);
      chk("t1_a_match", {7'd0, a_match}, 8'h01);
      cyc(0, 0, 0, 8'h00);
      chk("t1_ack_off",  {7'd0, b_ack},   8'h00);
      chk("t1_match_hold", {7'd0, b_match}, 8'h01);

      // 2: strap mismatch A1 -> ignore; later A6 without START stays ignored
      cyc(1, 0, 0, 8'h00);
      chk("t2_start_clr", {7'd0, b_match}, 8'h00);
      cyc(0, 0, 1, 8'hA1);
      chk("t2_match", {7'd0, b_match}, 8'h00);
      chk("t2_ack",   {7'd0, b_ack},   8'h00);
      chk("t2_devid", b_devid,         8'hA1);
      cyc(0, 0, 1, 8'hA6);
      chk("t2_late_match", {7'd0, b_match}, 8'h00);
      chk("t2_late_ack",   {7'd0, b_ack},   8'h00);
      chk("t2_late_devid", b_devid,         8'hA1);

      // 3: 10-bit write F4,50 then repeated-START read F5
      cyc(1, 0, 0, 8'h00);
      cyc(0, 0, 1, 8'hF4);
      chk("t3_ack1",   {7'd0, a_ack},   8'h01);
      chk("t3_match1", {7'd0, a_match}, 8'h00);
      chk("t3_b_ack1", {7'd0, b_ack},   8'h00);
      cyc(0, 0, 1, 8'h50);
      chk("t3_ack2",   {7'd0, a_ack},   8'h01);
      chk("t3_match2", {7'd0, a_match}, 8'h01);
      chk("t3_ten",    {7'd0, a_ten},   8'h01);
      chk("t3_wr",     {7'd0, a_wr},    8'h00);
      chk("t3_devid",  a_devid,         8'hF4);
      cyc(0, 0, 0, 8'h00);
      chk("t3_ack_off", {7'd0, a_ack}, 8'h00);
      cyc(1, 0, 0, 8'h00);
      chk("t3_rs_match", {7'd0, a_match}, 8'h00);
      chk("t3_rs_ten",   {7'd0, a_ten},   8'h00);
      chk("t3_rs_wr",    {7'd0, a_wr},    8'h00);
      cyc(0, 0, 1, 8'hF5);
      chk("t3_rd_match", {7'd0, a_match}, 8'h01);
      chk("t3_rd_wr",    {7'd0, a_wr},    8'h01);
      chk("t3_rd_ten",   {7'd0, a_ten},   8'h01);
      chk("t3_rd_ack",   {7'd0, a_ack},   8'h01);

      // 4: STOP clears history; byte in IDLE ignored; F5 after START ignored
      cyc(0, 1, 0, 8'h00);
      chk("t4_stop_match", {7'd0, a_match}, 8'h00);
      cyc(0, 0, 1, 8'hA7);
      chk("t4_idle_match", {7'd0, a_match}, 8'h00);
      chk("t4_idle_devid", a_devid,         8'hF5);
      cyc(1, 0, 0, 8'h00);
      cyc(0, 0, 1, 8'hF5);
      chk("t4_match", {7'd0, a_match}, 8'h00);
      chk("t4_ack",   {7'd0, a_ack},   8'h00);

      // 5: general call enabled on u_a, disabled on u_b
      cyc(1, 0, 0, 8'h00);
      cyc(0, 0, 1, 8'h00);
      chk("t5_gc",      {7'd0, a_gc},    8'h01);
      chk("t5_match",   {7'd0, a_match}, 8'h01);
      chk("t5_ack",     {7'd0, a_ack},   8'h01);
      chk("t5_b_gc",    {7'd0, b_gc},    8'h00);
      chk("t5_b_match", {7'd0, b_match}, 8'h00);
      chk("t5_b_ack",   {7'd0, b_ack},   8'h00);

      // 6: reset while in ADDR2, then START and byte strobe together
      cyc(1, 0, 0, 8'h00);
      cyc(0, 0, 1, 8'hF4);
      chk("t6_addr2_ack", {7'd0, a_ack}, 8'h01);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("t6_rst_ack",   {7'd0, a_ack},   8'h00);
      chk("t6_rst_wr",    {7'd0, a_wr},    8'h00);
      chk("t6_rst_devid", a_devid,         8'h00);
      chk("t6_rst_gc",    {7'd0, a_gc},    8'h00);
      @(posedge SCL);
      Reset_n = 1'b1;
      cyc(0, 0, 1, 8'h50);
      chk("t6_idle_match", {7'd0, a_match}, 8'h00);
      chk("t6_idle_ten",   {7'd0, a_ten},   8'h00);
      chk("t6_idle_ack",   {7'd0, a_ack},   8'h00);
      cyc(1, 0, 1, 8'hA7);
      chk("t6_sl_match", {7'd0, a_match}, 8'h00);
      chk("t6_sl_ack",   {7'd0, a_ack},   8'h00);
      chk("t6_sl_devid", a_devid,         8'h00);
      cyc(0, 0, 1, 8'hA7);
      chk("t6_after_match", {7'd0, a_match}, 8'h01);
      chk("t6_after_devid", a_devid,         8'hA7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
